ae_sccb_sched: RTL

- Sequences auto-exposure sensor updates onto the single SCCB register-write master.
- Arbitrates that master between the AE path and host (Avalon-side) single-register writes.
- Sits between the AE algorithm's cmos_change_start/cmos_change_done handshake and the SCCB write engine.
- Turns one exposure/gain update into an atomic burst of register writes.

---
 rtl/ae_sccb_pkg.sv | 57 +++++
 rtl/ae_sccb_rr_arb.sv | 40 ++++
 rtl/ae_sccb_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ae_sccb_pkg.sv
// Shared definitions for the auto-exposure SCCB write scheduler.
// Optional feature macro: AE_SCCB_GROUP_HOLD_EN (wraps each AE burst in a
// sensor group-hold start/end/launch sequence, 7 writes instead of 4).
package ae_sccb_pkg;

  // Scheduler FSM encoding, also exported on the debug port.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  // Owner of the last granted transaction.
  typedef enum logic {
    GNT_AE   = 1'b0,
    GNT_HOST = 1'b1
  } grant_t;

`ifdef AE_SCCB_GROUP_HOLD_EN
  // AE burst order with group hold wrapping the four value writes.
  typedef enum logic [2:0] {
    ST_GRP_START  = 3'd0,
    ST_EXPO_H     = 3'd1,
    ST_EXPO_L     = 3'd2,
    ST_GAIN_H     = 3'd3,
    ST_GAIN_L     = 3'd4,
    ST_GRP_END    = 3'd5,
    ST_GRP_LAUNCH = 3'd6
  } step_t;
  localparam step_t FIRST_STEP = ST_GRP_START;
  localparam step_t LAST_STEP  = ST_GRP_LAUNCH;
`else
  // Plain AE burst: exposure high/low, then gain high/low.
  typedef enum logic [1:0] {
    ST_EXPO_H = 2'd0,
    ST_EXPO_L = 2'd1,
    ST_GAIN_H = 2'd2,
    ST_GAIN_L = 2'd3
  } step_t;
  localparam step_t FIRST_STEP = ST_EXPO_H;
  localparam step_t LAST_STEP  = ST_GAIN_L;
`endif

  // Default sensor register map.
  localparam logic [15:0] DEF_EXPO_H_ADDR = 16'h3501;
  localparam logic [15:0] DEF_EXPO_L_ADDR = 16'h3502;
  localparam logic [15:0] DEF_GAIN_H_ADDR = 16'h350A;
  localparam logic [15:0] DEF_GAIN_L_ADDR = 16'h350B;
  localparam logic [15:0] DEF_GROUP_ADDR  = 16'h3212;

  // Group-hold control values: group 0 start, group 0 end, launch.
  localparam logic [7:0] GROUP_DATA_START  = 8'h00;
  localparam logic [7:0] GROUP_DATA_END    = 8'h10;
  localparam logic [7:0] GROUP_DATA_LAUNCH = 8'hA0;

endpackage

// File: rtl/ae_sccb_rr_arb.sv
// Two-requester round-robin arbiter (AE path vs host) for the SCCB master.
// Grants are combinational while en is high; last_grant remembers the winner
// so that on a tie the other requester goes next. Reset favours AE first.
module ae_sccb_rr_arb
  import ae_sccb_pkg::*;
(
  input  logic pclk,
  input  logic rst_n,
  input  logic en,
  input  logic req_ae,
  input  logic req_host,
  output logic gnt_ae,
  output logic gnt_host
);

  grant_t last_grant;

  // Pick the single requester, or the one opposite last_grant on a tie.
  always_comb begin
    gnt_ae   = 1'b0;
    gnt_host = 1'b0;
    if (en) begin
      if (req_ae && req_host) begin
        if (last_grant == GNT_HOST) gnt_ae = 1'b1;
        else                        gnt_host = 1'b1;
      end else begin
        gnt_ae   = req_ae;
        gnt_host = req_host;
      end
    end
  end

  // Remember who won the most recent grant.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)        last_grant <= GNT_HOST;
    else if (gnt_ae)   last_grant <= GNT_AE;
    else if (gnt_host) last_grant <= GNT_HOST;
  end

endmodule

// File: rtl/ae_sccb_sched.sv
// Auto-exposure SCCB write scheduler: turns one AE exposure/gain update into
// an atomic burst of sensor register writes and shares the single SCCB write
// master with host single-register writes (round-robin between the two).
// Optional feature macro: AE_SCCB_GROUP_HOLD_EN (group-hold wrapped burst).
//
// Handshakes:
//   SCCB  - sccb_valid is a one-cycle issue pulse, only emitted while
//           sccb_ready=1; sccb_addr/sccb_data hold from that pulse until the
//           one-cycle sccb_done pulse, which is honoured only in WAIT.
//   Host  - host_req is a level held until the one-cycle host_ack pulse,
//           which marks completion or a timeout abort.
//   AE    - a rising edge of ae_start captures exposure/gain; ae_done is low
//           while an update is pending or in flight.
module ae_sccb_sched
  import ae_sccb_pkg::*;
#(
  parameter int                   ADDR_BITS   = 16,
  parameter logic [ADDR_BITS-1:0] EXPO_H_ADDR = DEF_EXPO_H_ADDR,
  parameter logic [ADDR_BITS-1:0] EXPO_L_ADDR = DEF_EXPO_L_ADDR,
  parameter logic [ADDR_BITS-1:0] GAIN_H_ADDR = DEF_GAIN_H_ADDR,
  parameter logic [ADDR_BITS-1:0] GAIN_L_ADDR = DEF_GAIN_L_ADDR,
  parameter logic [ADDR_BITS-1:0] GROUP_ADDR  = DEF_GROUP_ADDR,
  parameter int                   TIMEOUT     = 1000000
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 ae_start,
  output logic                 ae_done,
  input  logic [9:0]           ae_exposure,
  input  logic [9:0]           ae_gain,
  input  logic                 host_req,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [7:0]           host_data,
  output logic                 host_ack,
  input  logic                 sccb_ready,
  output logic                 sccb_valid,
  output logic [ADDR_BITS-1:0] sccb_addr,
  output logic [7:0]           sccb_data,
  input  logic                 sccb_done,
  output logic                 err,
  input  logic                 err_clr,
  output state_t               dbg_state
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t         state;
  step_t          step;
  logic           own_ae;
  logic [TW-1:0]  tcnt;
  logic           ae_pend;
  logic           ae_start_q;
  logic [9:0]     exp_sh;
  logic [9:0]     gain_sh;
  logic           ae_rise;
  logic           gnt_ae;
  logic           gnt_host;
  logic [ADDR_BITS-1:0] step_addr;
  logic [7:0]     step_data;

  // A fresh rising edge counts as pending in the same cycle it is captured.
  assign ae_rise   = ae_start & ~ae_start_q;
  assign dbg_state = state;

  // The host still holds host_req in the cycle it sees host_ack; masking it
  // there keeps a completed write from being granted a second time.
  ae_sccb_rr_arb u_arb (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .en       (state == S_IDLE),
    .req_ae   (ae_pend | ae_rise),
    .req_host (host_req & ~host_ack),
    .gnt_ae   (gnt_ae),
    .gnt_host (gnt_host)
  );

`ifndef AE_SCCB_GROUP_HOLD_EN
  logic unused_group_addr;
  assign unused_group_addr = ^GROUP_ADDR;
`endif

  // Register address/data for the current AE burst step.
  always_comb begin
    step_addr = '0;
    step_data = '0;
    case (step)
      ST_EXPO_H: begin step_addr = EXPO_H_ADDR; step_data = {6'b0, exp_sh[9:8]};  end
      ST_EXPO_L: begin step_addr = EXPO_L_ADDR; step_data = exp_sh[7:0];          end
      ST_GAIN_H: begin step_addr = GAIN_H_ADDR; step_data = {6'b0, gain_sh[9:8]}; end
      ST_GAIN_L: begin step_addr = GAIN_L_ADDR; step_data = gain_sh[7:0];         end
`ifdef AE_SCCB_GROUP_HOLD_EN
      ST_GRP_START:  begin step_addr = GROUP_ADDR; step_data = GROUP_DATA_START;  end
      ST_GRP_END:    begin step_addr = GROUP_ADDR; step_data = GROUP_DATA_END;    end
      ST_GRP_LAUNCH: begin step_addr = GROUP_ADDR; step_data = GROUP_DATA_LAUNCH; end
`endif
      default: ;
    endcase
  end

  // Scheduler FSM with request capture, timeout and all registered outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      step       <= FIRST_STEP;
      own_ae     <= 1'b0;
      tcnt       <= '0;
      ae_pend    <= 1'b0;
      ae_start_q <= 1'b0;
      exp_sh     <= '0;
      gain_sh    <= '0;
      ae_done    <= 1'b1;
      host_ack   <= 1'b0;
      sccb_valid <= 1'b0;
      sccb_addr  <= '0;
      sccb_data  <= '0;
      err        <= 1'b0;
    end else begin
      sccb_valid <= 1'b0;
      host_ack   <= 1'b0;
      ae_start_q <= ae_start;
      if (err_clr) err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (gnt_ae || gnt_host) begin
            own_ae <= gnt_ae;
            step   <= FIRST_STEP;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sccb_ready) begin
            sccb_valid <= 1'b1;
            sccb_addr  <= own_ae ? step_addr : host_addr;
            sccb_data  <= own_ae ? step_data : host_data;
            tcnt       <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sccb_done) begin
            state <= S_NEXT;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // Timeout: flag it and drop the rest of the transaction.
            err   <= 1'b1;
            state <= S_IDLE;
            if (own_ae) begin
              ae_pend <= 1'b0;
              ae_done <= 1'b1;
            end else begin
              host_ack <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (own_ae) begin
            if (step == LAST_STEP) begin
              ae_pend <= 1'b0;
              ae_done <= 1'b1;
              state   <= S_IDLE;
            end else begin
              step  <= step_t'(step + 1'b1);
              state <= S_ISSUE;
            end
          end else begin
            host_ack <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A new AE edge overrides any completion in the same cycle; later
      // steps of an active burst pick up the newest shadowed values.
      if (ae_rise) begin
        exp_sh  <= ae_exposure;
        gain_sh <= ae_gain;
        ae_pend <= 1'b1;
        ae_done <= 1'b0;
      end
    end
  end

endmodule
